// File: rtl/mp_sub_serial_pkg.sv
// -----------------------------------------------------------------------------
// mp_sub_pkg
// Shared types and sizing helpers for the serial multi-precision subtractor.
//   stateT   : controller states (IDLE, CALC, DONE)
//   dbgT     : debug snapshot exported by the top level
//   nChunk   : number of CHUNK-bit slices in a WIDTH-bit operand
//   cntWidth : chunk counter width, never less than one bit
// -----------------------------------------------------------------------------
package mp_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } stateT;

    // Debug view of the controller. chunkG/chunkP reflect the slice that is
    // being evaluated this cycle and are only meaningful while in CALC.
    typedef struct packed {
        stateT state;
        logic  borrow;
        logic  chunkG;
        logic  chunkP;
    } dbgT;

    function automatic int nChunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cntWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mp_sub_serial_if.sv
// -----------------------------------------------------------------------------
// mp_sub_serial_if
// Operand/result bus of the serial subtractor.
//   iValid/oReady : operand handshake (iA, iB, iBin travel with it)
//   oValid/iReady : result handshake (oDiff, oBout, oZero travel with it)
// Handshake rule, both directions: a transfer happens on a rising clock edge
// where valid and ready are both 1; the sender holds its payload stable while
// valid is 1 and ready is 0; valid is never withdrawn by the receiver.
// modport master : the side that supplies operands and consumes results
// modport slave  : the subtractor itself
// -----------------------------------------------------------------------------
interface mp_sub_serial_if #(
    parameter int WIDTH = 256
);
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iBin;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oDiff;
    logic             oBout;
    logic             oZero;

    modport master (
        output iValid, iA, iB, iBin, iReady,
        input  oReady, oValid, oDiff, oBout, oZero
    );

    modport slave (
        input  iValid, iA, iB, iBin, iReady,
        output oReady, oValid, oDiff, oBout, oZero
    );
endinterface

// File: rtl/mp_sub_serial_sub_chunk.sv
// -----------------------------------------------------------------------------
// sub_chunk
// Combinational CHUNK-bit borrow-propagate subtract slice: oDiff = iA - iB - iBin.
//   iA, iB : CHUNK-bit operands
//   iBin   : borrow in
//   oDiff  : CHUNK-bit difference (modulo 2^CHUNK)
//   oBout  : borrow out
//   oG     : slice generates a borrow on its own (iA < iB)
//   oP     : slice passes an incoming borrow through (iA == iB)
// oBout always equals oG | (oP & iBin); G/P are exported so a lookahead
// variant can reuse this slice unchanged.
// -----------------------------------------------------------------------------
module sub_chunk #(
    parameter int CHUNK = 32
) (
    input  logic [CHUNK-1:0] iA,
    input  logic [CHUNK-1:0] iB,
    input  logic             iBin,
    output logic [CHUNK-1:0] oDiff,
    output logic             oBout,
    output logic             oG,
    output logic             oP
);
    // One extra bit catches the borrow: the result goes negative exactly when
    // iA < iB + iBin, which sets the top bit of the widened difference.
    logic [CHUNK:0] wide;

    assign wide  = {1'b0, iA} - {1'b0, iB} - {{CHUNK{1'b0}}, iBin};
    assign oDiff = wide[CHUNK-1:0];
    assign oBout = wide[CHUNK];
    assign oG    = (iA < iB);
    assign oP    = (iA == iB);

endmodule

// File: rtl/mp_sub_serial.sv
// -----------------------------------------------------------------------------
// mp_sub_serial
// Serial multi-precision subtractor: oDiff = iA - iB - iBin over WIDTH bits,
// one CHUNK-bit slice per clock, least-significant chunk first.
//   iClk  : clock, rising edge
//   iRst  : asynchronous active-high reset
//   bus   : operand/result handshake bus (slave side)
//   oDbg  : controller state, running borrow and current slice G/P
// Timing (accept edge = edge 0): chunks 0..NCHUNK-1 are written on edges
// 1..NCHUNK, which also moves the controller into DONE and registers oBout and
// oZero; oValid rises one edge later (edge NCHUNK+1). oReady returns on the
// edge where the result is taken, so operations are at least NCHUNK+3 cycles
// apart. WIDTH must be a multiple of CHUNK and CHUNK must be at least 1.
// -----------------------------------------------------------------------------
module mp_sub_serial
    import mp_sub_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int CHUNK = 32
) (
    input  logic                iClk,
    input  logic                iRst,
    mp_sub_serial_if.slave      bus,
    output dbgT                 oDbg
);
    localparam int NCHUNK = nChunk(WIDTH, CHUNK);
    localparam int CW     = cntWidth(NCHUNK);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    stateT            state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic             borrow;
    logic [WIDTH-1:0] diffReg;
    logic             boutReg;
    logic             zeroReg;
    logic             readyReg;
    logic             validReg;

    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic [CHUNK-1:0] sliceDiff;
    logic             sliceBout;
    logic             chunkG;
    logic             chunkP;
    logic [WIDTH-1:0] diffNext;

    // Chunk selection is a constant-index mux rather than a variable part
    // select, keeping every index width exact.
    always_comb begin
        aChunk = '0;
        bChunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt == CW'(k)) begin
                aChunk = aReg[k*CHUNK +: CHUNK];
                bChunk = bReg[k*CHUNK +: CHUNK];
            end
        end
    end

    sub_chunk #(
        .CHUNK (CHUNK)
    ) uSlice (
        .iA    (aChunk),
        .iB    (bChunk),
        .iBin  (borrow),
        .oDiff (sliceDiff),
        .oBout (sliceBout),
        .oG    (chunkG),
        .oP    (chunkP)
    );

    // Result register with the current chunk replaced; untouched chunks keep
    // their previous contents. Also feeds the zero flag on the final chunk so
    // oZero sees the complete difference on the DONE entry edge.
    always_comb begin
        diffNext = diffReg;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt == CW'(k)) begin
                diffNext[k*CHUNK +: CHUNK] = sliceDiff;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            cnt      <= '0;
            aReg     <= '0;
            bReg     <= '0;
            borrow   <= 1'b0;
            diffReg  <= '0;
            boutReg  <= 1'b0;
            zeroReg  <= 1'b0;
            readyReg <= 1'b1;
            validReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iValid && readyReg) begin
                        aReg     <= bus.iA;
                        bReg     <= bus.iB;
                        borrow   <= bus.iBin;
                        cnt      <= '0;
                        readyReg <= 1'b0;
                        state    <= CALC;
                    end
                end

                CALC: begin
                    diffReg <= diffNext;
                    borrow  <= sliceBout;
                    if (cnt == LAST_CNT) begin
                        cnt     <= '0;
                        boutReg <= sliceBout;
                        zeroReg <= ~|diffNext;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    // First DONE cycle raises oValid; the transfer can only
                    // complete once the result has been presented.
                    if (!validReg) begin
                        validReg <= 1'b1;
                    end else if (bus.iReady) begin
                        validReg <= 1'b0;
                        readyReg <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    readyReg <= 1'b1;
                    validReg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.oReady = readyReg;
    assign bus.oValid = validReg;
    assign bus.oDiff  = diffReg;
    assign bus.oBout  = boutReg;
    assign bus.oZero  = zeroReg;

    assign oDbg.state  = state;
    assign oDbg.borrow = borrow;
    assign oDbg.chunkG = chunkG;
    assign oDbg.chunkP = chunkP;

endmodule
